// File: rtl/cpu_dma_ctrl_pkg.sv
// Shared types for the 6502 DMA front-end: controller state encoding and the
// per-channel mode word layout.
package cpu_dma_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    HALT,
    ALIGN,
    GET,
    PUT,
    DONE
  } dma_state_t;

  // Bit 1 increments the destination, bit 0 selects copy (1) or read-only (0).
  typedef struct packed {
    logic inc_dst;
    logic copy;
  } dma_mode_t;

endpackage

// File: rtl/cpu_dma_ctrl_prio_enc.sv
// Fixed-priority arbiter: one-hot grant of the lowest set request index,
// plus a flag saying any request is present.
module prio_enc #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant,
  output logic              valid
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/cpu_dma_ctrl.sv
// Multi-channel bus-master DMA front-end: stalls the 6502 through cpu_ready,
// then runs copy (GET/PUT) or read-only (GET) transfers aligned to bus parity.
module cpu_dma_ctrl
  import cpu_dma_ctrl_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_rw,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic                     cpu_ready,
  output logic                     bus_rw,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  input  logic [DATA_W-1:0]        bus_rdata,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_src,
  input  logic [NUM_CH*ADDR_W-1:0] ch_dst,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  input  logic [NUM_CH*2-1:0]      ch_mode,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [DATA_W-1:0]        ch_rdata
);

  dma_state_t        state, state_nxt;
  logic              parity;
  logic [NUM_CH-1:0] pend_grant, grant;
  logic              pend_valid;

  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W:0]    cnt;
  dma_mode_t         mode;
  logic [DATA_W-1:0] buffer;
  logic              last;

  logic [ADDR_W-1:0] sel_src, sel_dst;
  logic [LEN_W-1:0]  sel_len;
  dma_mode_t         sel_mode;

  prio_enc #(.NUM_CH(NUM_CH)) u_prio (
    .req   (ch_req),
    .grant (pend_grant),
    .valid (pend_valid)
  );

  // Pick the winning channel's descriptor out of the flattened port vectors.
  always_comb begin
    sel_src  = '0;
    sel_dst  = '0;
    sel_len  = '0;
    sel_mode = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend_grant[i]) begin
        sel_src  = ch_src[i*ADDR_W +: ADDR_W];
        sel_dst  = ch_dst[i*ADDR_W +: ADDR_W];
        sel_len  = ch_len[i*LEN_W +: LEN_W];
        sel_mode = dma_mode_t'(ch_mode[i*2 +: 2]);
      end
    end
  end

  assign last = (cnt == (LEN_W + 1)'(1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (pend_valid) state_nxt = HALT_WAIT;
      HALT_WAIT: if (cpu_rw) state_nxt = HALT;
      // parity flips at the edge, so odd now means the next cycle is a GET slot.
      HALT:      state_nxt = parity ? GET : ALIGN;
      ALIGN:     state_nxt = GET;
      GET: begin
        if (mode.copy)  state_nxt = PUT;
        else if (last)  state_nxt = DONE;
        else            state_nxt = ALIGN;
      end
      PUT:       state_nxt = last ? DONE : GET;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, so a reset mid-transfer leaves no stale descriptor behind.
      state     <= IDLE;
      parity    <= 1'b0;
      cpu_ready <= 1'b1;
      ch_done   <= '0;
      ch_rdata  <= '0;
      grant     <= '0;
      src       <= '0;
      dst       <= '0;
      cnt       <= '0;
      mode      <= '0;
      buffer    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= state_nxt;
      parity  <= ~parity;
      ch_done <= (state_nxt == DONE) ? grant : '0;

      if (state == HALT_WAIT && cpu_rw) cpu_ready <= 1'b0;
      else if (state_nxt == DONE)       cpu_ready <= 1'b1;

      unique case (state)
        IDLE: begin
          if (pend_valid) begin
            grant <= pend_grant;
            src   <= sel_src;
            dst   <= sel_dst;
            cnt   <= (sel_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, sel_len};
            mode  <= sel_mode;
          end
        end
        GET: begin
          buffer   <= bus_rdata;
          ch_rdata <= bus_rdata;
          src      <= src + 1'b1;
          if (!mode.copy) cnt <= cnt - 1'b1;
        end
        PUT: begin
          if (mode.inc_dst) dst <= dst + 1'b1;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The core owns the bus whenever the controller is not mid-transfer.
  always_comb begin
    bus_rw    = cpu_rw;
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    unique case (state)
      HALT, ALIGN, GET: begin
        bus_rw    = 1'b1;
        bus_addr  = src;
        bus_wdata = buffer;
      end
      PUT: begin
        bus_rw    = 1'b0;
        bus_addr  = dst;
        bus_wdata = buffer;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_dma_ctrl.sv
// Self-checking bench for cpu_dma_ctrl: table-driven transfers, hand-written
// corner sequences, and randomized transfers against a transaction-level model.
module tb_cpu_dma_ctrl;

  localparam int NUM_CH = 2;
  localparam int LEN_W  = 8;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     cpu_rw;
  logic [ADDR_W-1:0]        cpu_addr;
  logic [DATA_W-1:0]        cpu_wdata;
  logic                     cpu_ready;
  logic                     bus_rw;
  logic [ADDR_W-1:0]        bus_addr;
  logic [DATA_W-1:0]        bus_wdata;
  logic [DATA_W-1:0]        bus_rdata;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*ADDR_W-1:0] ch_src;
  logic [NUM_CH*ADDR_W-1:0] ch_dst;
  logic [NUM_CH*LEN_W-1:0]  ch_len;
  logic [NUM_CH*2-1:0]      ch_mode;
  logic [NUM_CH-1:0]        ch_done;
  logic [DATA_W-1:0]        ch_rdata;

  cpu_dma_ctrl #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_rw    (cpu_rw),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .bus_rw    (bus_rw),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .ch_req    (ch_req),
    .ch_src    (ch_src),
    .ch_dst    (ch_dst),
    .ch_len    (ch_len),
    .ch_mode   (ch_mode),
    .ch_done   (ch_done),
    .ch_rdata  (ch_rdata)
  );

  always #5 clk = ~clk;

  // Bus memory: combinational read, writes are only logged.
  logic [7:0] mem [0:65535];
  assign bus_rdata = mem[bus_addr];

  // Free-running parity as the bus defines it: 0 out of reset, flips every edge.
  logic tb_par;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_par <= 1'b0;
    else        tb_par <= ~tb_par;

  int checks = 0;
  int errors = 0;

  int stall_cnt, done0, done1, onehot_bad;
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (!cpu_ready) stall_cnt++;
      if (ch_done[0]) done0++;
      if (ch_done[1]) done1++;
      if ($countones(ch_done) > 1) onehot_bad++;
      if (!bus_rw) begin
        wr_addr_q.push_back(bus_addr);
        wr_data_q.push_back(bus_wdata);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    stall_cnt = 0;
    done0 = 0;
    done1 = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic load_ch(input int ch, input logic [15:0] src, input logic [15:0] dst,
                         input logic [7:0] len, input logic [1:0] mode);
    ch_src[ch*ADDR_W +: ADDR_W] = src;
    ch_dst[ch*ADDR_W +: ADDR_W] = dst;
    ch_len[ch*LEN_W +: LEN_W]   = len;
    ch_mode[ch*2 +: 2]          = mode;
  endtask

  // Transaction-level cost: one HALT, an optional ALIGN, then a GET/PUT pair per
  // copied byte, or GET plus a realigning dummy cycle between read-only bytes.
  function automatic int model_stall(input bit copy, input int n, input bit align);
    return copy ? (2 * n + 1 + int'(align)) : (2 * n + int'(align));
  endfunction

  // Entered and left at posedge+#1. align=1 requests in an even IDLE cycle so
  // HALT lands on parity 0 and an ALIGN cycle is needed. The request is dropped
  // as soon as the core stalls; the transfer must still run to the end.
  task automatic run_xfer(input int ch, input logic [15:0] src, input logic [15:0] dst,
                          input logic [7:0] len, input logic [1:0] mode, input bit align,
                          output bit seen);
    clear_mon();
    load_ch(ch, src, dst, len, mode);
    while (tb_par != !align) begin
      @(posedge clk); #1;
    end
    ch_req[ch] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      if (!cpu_ready) ch_req[ch] = 1'b0;
      if (ch_done[ch]) seen = 1'b1;
    end
    ch_req[ch] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic verify(input string tag, input int ch, input logic [15:0] src,
                        input logic [15:0] dst, input logic [7:0] len, input logic [1:0] mode,
                        input int exp_stall, input bit seen);
    int n, bad;
    logic [15:0] a;
    n = (len == 8'd0) ? 256 : int'(len);
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_stall"}, stall_cnt, exp_stall);
    check({tag, "_done_own"}, (ch == 0) ? done0 : done1, 32'd1);
    check({tag, "_done_other"}, (ch == 0) ? done1 : done0, 32'd0);
    check({tag, "_nwrites"}, wr_addr_q.size(), mode[0] ? n : 0);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size() && i < n; i++) begin
      a = src + 16'(i);
      if (wr_addr_q[i] !== (mode[1] ? dst + 16'(i) : dst) || wr_data_q[i] !== mem[a]) bad++;
    end
    check({tag, "_wdata_bad"}, bad, 32'd0);
    a = src + 16'(n - 1);
    check({tag, "_rdata"}, ch_rdata, mem[a]);
  endtask

  typedef struct {
    int          ch;
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  len;
    logic [1:0]  mode;
    bit          align;
    int          stall;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit seen;
    int d0_at, d1_at, free_cyc;
    bit ch1_started;
    logic [15:0] wa [3];
    logic [7:0]  wd [3];

    vecs[0] = '{0, 16'h0200, 16'h2004, 8'h00, 2'b01, 1'b0, 513};
    vecs[1] = '{0, 16'h0200, 16'h2004, 8'h00, 2'b01, 1'b1, 514};
    vecs[2] = '{1, 16'hC000, 16'h0000, 8'h01, 2'b00, 1'b0, 2};
    vecs[3] = '{1, 16'hC000, 16'h0000, 8'h01, 2'b00, 1'b1, 3};
    vecs[4] = '{0, 16'hFFFE, 16'h3000, 8'h04, 2'b11, 1'b0, 9};
    vecs[5] = '{1, 16'h1234, 16'h0000, 8'h03, 2'b00, 1'b1, 7};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hC000] = 8'h5A;

    rst_n = 1'b0;
    cpu_rw = 1'b1;
    cpu_addr = 16'h8123;
    cpu_wdata = 8'h00;
    ch_req = '0;
    ch_src = '0;
    ch_dst = '0;
    ch_len = '0;
    ch_mode = '0;
    onehot_bad = 0;
    clear_mon();

    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_ready", cpu_ready, 1);
    check("rst_ch_done", ch_done, 0);
    check("rst_ch_rdata", ch_rdata, 0);
    check("rst_passthru", {bus_rw, bus_addr}, {1'b1, 16'h8123});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven transfers.
    for (int v = 0; v < 6; v++) begin
      run_xfer(vecs[v].ch, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].mode, vecs[v].align, seen);
      verify($sformatf("vec%0d", v), vecs[v].ch, vecs[v].src, vecs[v].dst, vecs[v].len,
             vecs[v].mode, vecs[v].stall, seen);
    end

    // Core issues three writes while a request is pending: no stall until a read.
    clear_mon();
    load_ch(0, 16'h0300, 16'h5000, 8'h02, 2'b11);
    wa = '{16'h4000, 16'h4001, 16'h4002};
    wd = '{8'h11, 8'h22, 8'h33};
    ch_req[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cpu_rw = 1'b0;
      cpu_addr = wa[k];
      cpu_wdata = wd[k];
      #2;
      check($sformatf("wr%0d_ready", k), cpu_ready, 1);
      check($sformatf("wr%0d_bus", k), {bus_rw, bus_addr, bus_wdata}, {1'b0, wa[k], wd[k]});
      @(posedge clk); #1;
    end
    cpu_rw = 1'b1;
    cpu_addr = 16'h8200;
    #2;
    check("wr_read_ready", cpu_ready, 1);
    @(posedge clk); #1;
    check("wr_halt_ready", cpu_ready, 0);
    ch_req[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (ch_done[0]) seen = 1'b1;
    end
    check("wr_xfer_done", 32'(seen), 1);
    repeat (2) begin
      @(posedge clk); #1;
    end

    // Simultaneous requests: ch0 first, core gets free cycles, then ch1.
    clear_mon();
    load_ch(0, 16'h0400, 16'h6000, 8'h02, 2'b11);
    load_ch(1, 16'hC000, 16'h0000, 8'h01, 2'b00);
    ch_req = 2'b11;
    d0_at = -1;
    d1_at = -1;
    free_cyc = 0;
    ch1_started = 1'b0;
    for (int i = 0; i < 200 && d1_at < 0; i++) begin
      @(posedge clk); #1;
      if (ch_done[0] && d0_at < 0) begin
        d0_at = i;
        ch_req[0] = 1'b0;
      end
      if (d0_at >= 0 && !ch1_started) begin
        if (cpu_ready) free_cyc++;
        else           ch1_started = 1'b1;
      end
      if (ch_done[1]) begin
        d1_at = i;
        ch_req[1] = 1'b0;
      end
    end
    check("both_ch0_done", 32'(d0_at >= 0), 1);
    check("both_ch0_first", 32'(d1_at > d0_at), 1);
    check("both_free_cycle", 32'(free_cyc >= 1), 1);
    check("both_ch1_rdata", ch_rdata, 8'h5A);
    repeat (3) begin
      @(posedge clk); #1;
    end

    // Reset at byte 10 of a full-page copy.
    clear_mon();
    load_ch(0, 16'h0200, 16'h2004, 8'h00, 2'b01);
    ch_req[0] = 1'b1;
    for (int i = 0; i < 100 && wr_addr_q.size() < 10; i++) begin
      @(posedge clk); #1;
    end
    check("abort_reached_byte10", wr_addr_q.size(), 10);
    #2;
    rst_n = 1'b0;
    ch_req[0] = 1'b0;
    #1;
    check("abort_ready", cpu_ready, 1);
    check("abort_done", ch_done, 0);
    check("abort_passthru", {bus_rw, bus_addr}, {cpu_rw, cpu_addr});
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("abort_rdata", ch_rdata, 0);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("abort_no_done", done0 + done1, 0);
    check("abort_idle_ready", cpu_ready, 1);
    run_xfer(1, 16'hC000, 16'h0000, 8'h01, 2'b00, 1'b0, seen);
    verify("post_rst", 1, 16'hC000, 16'h0000, 8'h01, 2'b00, 2, seen);

    // Randomized transfers against the model.
    for (int r = 0; r < 10; r++) begin
      int          ch;
      logic [15:0] src, dst;
      logic [7:0]  len;
      logic [1:0]  mode;
      bit          align;
      ch    = int'($urandom_range(0, 1));
      src   = 16'($urandom);
      dst   = 16'($urandom);
      len   = 8'($urandom_range(1, 12));
      mode  = 2'($urandom);
      align = 1'($urandom);
      run_xfer(ch, src, dst, len, mode, align, seen);
      verify($sformatf("rnd%0d", r), ch, src, dst, len, mode,
             model_stall(mode[0], int'(len), align), seen);
    end

    check("done_onehot", onehot_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
